// File: rtl/nibble_serial_adder_controller_pkg.sv
`default_nettype none
// ==================================================================
// nibble_serial_adder_controller_pkg: shared state encoding, nibble width
// Rev 1.0
// ==================================================================
package nibble_serial_adder_controller_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/nibble_serial_adder_controller_lacg.sv
`default_nettype none
// ==================================================================
// look_ahead_carry_generator_4_bit: 4-bit adder with look-ahead carries
// Rev 1.0
// ==================================================================
module look_ahead_carry_generator_4_bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] gen;
    logic [3:0] prop;
    logic [4:0] c;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Every carry is a flat sum of products of g/p, so no ripple chain
    assign c[0] = cin;
    assign c[1] = gen[0] | (prop[0] & cin);
    assign c[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & cin);
    assign c[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
                | (prop[2] & prop[1] & prop[0] & cin);
    assign c[4] = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
                | (prop[3] & prop[2] & prop[1] & gen[0])
                | (prop[3] & prop[2] & prop[1] & prop[0] & cin);

    assign sum  = prop ^ c[3:0];
    assign cout = c[4];

endmodule
`default_nettype wire

// File: rtl/nibble_serial_adder_controller.sv
`default_nettype none
// ==================================================================
// nibble_serial_adder_controller: WIDTH-bit add, one nibble per cycle
// Rev 1.0
// ==================================================================
module nibble_serial_adder_controller
    import nibble_serial_adder_controller_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int                NIBBLES  = WIDTH / NIBBLE_W;
    localparam int                IDX_W    = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t               state;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic                 carry;
    logic [IDX_W-1:0]     idx;

    logic [NIBBLE_W-1:0]  nib_a;
    logic [NIBBLE_W-1:0]  nib_b;
    logic [NIBBLE_W-1:0]  nib_sum;
    logic                 nib_cout;

    assign nib_a = op_a[idx*NIBBLE_W +: NIBBLE_W];
    assign nib_b = op_b[idx*NIBBLE_W +: NIBBLE_W];

    look_ahead_carry_generator_4_bit u_lacg (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    sum[idx*NIBBLE_W +: NIBBLE_W] <= nib_sum;
                    carry <= nib_cout;
                    idx   <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        carry_out <= nib_cout;
                        // The MSB of the sum is being produced this very cycle
                        overflow  <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                                     (nib_sum[NIBBLE_W-1] != op_a[WIDTH-1]);
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request
                    done <= 1'b0;
                    if (start) begin
                        op_a  <= data_a;
                        op_b  <= data_b;
                        carry <= carry_in;
                        idx   <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ==================================================================
// tb_nibble_serial_adder_controller: scoreboard bench, 16- and 8-bit builds
// Rev 1.0
// ==================================================================
module tb_nibble_serial_adder_controller;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start16, start8;
    logic [15:0] a16, b16;
    logic [7:0]  a8, b8;
    logic        c16, c8;
    logic        busy16, done16, cout16, ovf16;
    logic        busy8, done8, cout8, ovf8;
    logic [15:0] sum16;
    logic [7:0]  sum8;

    res_t q16[$];
    res_t q8[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   pushed16 = 0, pushed8 = 0;
    int   done_cnt16 = 0, done_cnt8 = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    nibble_serial_adder_controller #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .data_a(a16), .data_b(b16),
        .carry_in(c16), .busy(busy16), .done(done16), .sum(sum16),
        .carry_out(cout16), .overflow(ovf16)
    );

    nibble_serial_adder_controller #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .data_a(a8), .data_b(b8),
        .carry_in(c8), .busy(busy8), .done(done8), .sum(sum8),
        .carry_out(cout8), .overflow(ovf8)
    );

    // Reference: plain integer addition, then read off the bits the spec names
    function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic c, input int w);
        logic [16:0] full;
        logic [15:0] mask;
        res_t        r;
        mask  = (w == 16) ? 16'hFFFF : 16'h00FF;
        full  = {1'b0, a & mask} + {1'b0, b & mask} + {16'h0, c};
        r.sum  = full[15:0] & mask;
        r.cout = full[w];
        r.ovf  = (a[w-1] == b[w-1]) && (r.sum[w-1] != a[w-1]);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        res_t e;
        if (done16) begin
            done_cnt16++;
            check("busy_done_excl16", {31'd0, busy16}, 32'd0);
            if (q16.size() == 0) begin
                check("unexpected_done16", 32'd1, 32'd0);
            end else begin
                e = q16.pop_front();
                check("sum16", {16'd0, sum16}, {16'd0, e.sum});
                check("cout16", {31'd0, cout16}, {31'd0, e.cout});
                check("ovf16", {31'd0, ovf16}, {31'd0, e.ovf});
            end
        end
        if (done8) begin
            done_cnt8++;
            if (q8.size() == 0) begin
                check("unexpected_done8", 32'd1, 32'd0);
            end else begin
                e = q8.pop_front();
                check("sum8", {24'd0, sum8}, {16'd0, e.sum});
                check("cout8", {31'd0, cout8}, {31'd0, e.cout});
                check("ovf8", {31'd0, ovf8}, {31'd0, e.ovf});
            end
        end
    end

    // Called and returns at posedge+1; waits for an accepting state, then starts
    task automatic issue(input bit w8, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input bit push);
        int n = 0;
        while ((w8 ? busy8 : busy16) && n < 40) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 40) check("accept_timeout", 32'd1, 32'd0);
        if (w8) begin
            a8 = a[7:0]; b8 = b[7:0]; c8 = c; start8 = 1'b1;
            if (push) begin q8.push_back(model(a, b, c, 8)); pushed8++; end
        end else begin
            a16 = a; b16 = b; c16 = c; start16 = 1'b1;
            if (push) begin q16.push_back(model(a, b, c, 16)); pushed16++; end
        end
        @(posedge clk); #1;
        start8 = 1'b0; start16 = 1'b0;
    endtask

    task automatic wait_done16(output int t);
        int n = 0;
        while (!done16 && n < 20) begin @(posedge clk); #1; n++; end
        if (n >= 20) check("done_timeout", 32'd1, 32'd0);
        t = cyc;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_n, done_at, t, t_prev, n;
        logic [15:0] ra, rb;
        rst = 1'b1; start16 = 0; start8 = 0;
        a16 = 0; b16 = 0; c16 = 0; a8 = 0; b8 = 0; c8 = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sum", {16'd0, sum16}, 32'd0);
        check("rst_busy_done", {30'd0, busy16, done16}, 32'd0);
        check("rst_cout_ovf", {30'd0, cout16, ovf16}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Latency: 4 busy cycles, done in the 5th cycle after accept
        issue(0, 16'hFFFF, 16'h0001, 1'b0, 1);
        busy_n = 0; done_at = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (busy16) busy_n++;
            if (done16 && done_at == 0) done_at = i;
        end
        @(posedge clk); #1;
        check("busy_cycles", busy_n, 32'd4);
        check("done_latency", done_at, 32'd5);

        issue(0, 16'h7FFF, 16'h0001, 1'b0, 1);
        issue(0, 16'h8000, 16'h8000, 1'b0, 1);

        // A start pulse during RUN must be ignored
        issue(0, 16'h1234, 16'h4321, 1'b1, 1);
        @(posedge clk); #1;
        start16 = 1'b1; a16 = 16'hFFFF; b16 = 16'hFFFF;
        @(posedge clk); #1;
        start16 = 1'b0;

        // Reset two cycles into RUN discards the operation
        issue(0, 16'hAAAA, 16'h5555, 1'b1, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrun_rst_sum", {16'd0, sum16}, 32'd0);
        check("midrun_rst_flags", {28'd0, busy16, done16, cout16, ovf16}, 32'd0);
        issue(0, 16'h00FF, 16'h0001, 1'b0, 1);

        // Start held high: a new result every NIBBLES+1 cycles
        n = 0;
        while (busy16 && n < 40) begin @(posedge clk); #1; n++; end
        ra = 16'($urandom); rb = 16'($urandom);
        a16 = ra; b16 = rb; c16 = 1'b1; start16 = 1'b1;
        q16.push_back(model(ra, rb, 1'b1, 16)); pushed16++;
        @(posedge clk); #1;
        t_prev = 0;
        for (int i = 0; i < 6; i++) begin
            wait_done16(t);
            if (i > 0) check("b2b_interval", t - t_prev, 32'd5);
            t_prev = t;
            if (i < 5) begin
                ra = 16'($urandom); rb = 16'($urandom);
                a16 = ra; b16 = rb; c16 = 1'($urandom);
                q16.push_back(model(ra, rb, c16, 16)); pushed16++;
            end else begin
                start16 = 1'b0;
            end
            @(posedge clk); #1;
        end

        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            issue(0, 16'($urandom), 16'($urandom), 1'($urandom), 1);
        end
        issue(1, 16'h00FF, 16'h0001, 1'b0, 1);
        issue(1, 16'h007F, 16'h0001, 1'b0, 1);
        for (int i = 0; i < 100; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            issue(1, 16'($urandom), 16'($urandom), 1'($urandom), 1);
        end

        n = 0;
        while ((q16.size() != 0 || q8.size() != 0) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("drain16", q16.size(), 32'd0);
        check("drain8", q8.size(), 32'd0);
        check("done_count16", done_cnt16, pushed16);
        check("done_count8", done_cnt8, pushed8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nibble_serial_adder_controller.md
# nibble_serial_adder_controller

Sequencing controller that performs a WIDTH-bit addition by driving one shared 4-bit look-ahead carry generator over successive cycles, one nibble per cycle, LSB first. It latches operands on a start handshake, walks a nibble counter, ripples the carry through a register between nibble steps, and assembles the result. It sits between a requesting datapath and the 4-bit adder, trading latency for area on wide adds.

## Interface

- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
- NIBBLES, WIDTH/4, derived nibble step count; not overridden.

- Clock  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- Start_In  input  1  request to begin an add; sampled only when accepting (IDLE or DONE).
- Data_A_In  input  WIDTH  operand A; latched on accepted Start_In.
- Data_B_In  input  WIDTH  operand B; latched on accepted Start_In.
- Carry_In  input  1  initial carry; latched on accepted Start_In.
- Busy_Out  output  1  high while in RUN.
- Done_Out  output  1  one-cycle pulse; result valid this cycle and held afterwards.
- Sum_Out  output  WIDTH  registered result.
- Carry_Out  output  1  carry out of the MSB nibble.
- Overflow_Out  output  1  two's-complement overflow of the full-width add.

## Operation

- States: IDLE, RUN, DONE.
- IDLE: Start_In=1 latches A, B, Carry_In into operand and carry registers, clears the nibble counter, and moves to RUN. Start_In=0 keeps the state at IDLE.
- RUN: each cycle applies nibble[idx] of A and B plus the carry register to the 4-bit adder. The 4-bit sum is written to Sum_Out[4*idx+3:4*idx]. The adder Carry_Out is written to the carry register, and idx is incremented.
  - When idx = NIBBLES-1 the state moves to DONE.
  - Start_In is ignored throughout RUN.
- DONE: Done_Out=1. Carry_Out and Overflow_Out are presented. Overflow_Out = (A[MSB]==B[MSB]) && (Sum[MSB]!=A[MSB]), using the latched operands.
  - Start_In=1 in DONE is accepted exactly as in IDLE, giving back-to-back operation: next state RUN.
  - Otherwise the next state is IDLE.
- Sum_Out, Carry_Out and Overflow_Out hold their last values in IDLE until the next accepted Start_In. Sum_Out nibbles are overwritten progressively during RUN.
- Operand inputs are don't-care except on the accepting edge.
- Reset (any state, including mid-RUN) forces the following, and any in-flight operation is discarded:
  - state to IDLE;
  - counter, carry register and operand registers to 0;
  - Sum_Out, Carry_Out, Overflow_Out, Busy_Out and Done_Out to 0.

## Timing

- Start_In is accepted at edge k. Busy_Out is high for cycles k+1 … k+NIBBLES. Done_Out is high in cycle k+NIBBLES+1. For WIDTH=16: 4 busy cycles, Done 5 cycles after the accepting edge.
- Throughput with back-to-back Start_In is one result per NIBBLES+1 cycles.
- The only combinational path is nibble mux → 4-bit adder → register. There is no input-to-output combinational path.
- Busy_Out and Done_Out are never high in the same cycle.

## Structure

- Shared package: a state enum (IDLE, RUN, DONE) and a NIBBLE_W = 4 constant.
- One sub-module: the existing 4-bit look-ahead carry generator (Look_Ahead_Carry_Generator_4_Bit), instantiated once. All sequencing, muxing and registers live in this block.

## Test plan

- 0xFFFF + 0x0001, Carry_In=0 → Sum_Out=0x0000, Carry_Out=1, Overflow_Out=0. Done_Out pulses exactly 5 cycles after Start_In; Busy_Out is high for exactly 4 cycles.
- 0x7FFF + 0x0001, Carry_In=0 → Sum_Out=0x8000, Carry_Out=0, Overflow_Out=1. Also 0x8000 + 0x8000 → 0x0000, Carry_Out=1, Overflow_Out=1.
- 0x1234 + 0x4321, Carry_In=1 started, then Start_In with 0xFFFF/0xFFFF pulsed during RUN → the second request is ignored. Result is 0x5556, Carry_Out=0, and only one Done_Out pulse occurs.
- Reset asserted 2 cycles into RUN → next cycle all outputs are 0 and state is IDLE. A fresh Start of 0x00FF + 0x0001 then completes normally with 0x0100.
- Start_In held high continuously with new operands presented each Done cycle → results every 5 cycles, each matching the reference sum (A+B+Cin).
- 200 random WIDTH=16 operand/carry sets, plus a WIDTH=8 build → Sum_Out, Carry_Out and Overflow_Out match a behavioural model on every Done_Out.
